muldiv_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller beside the execute stage ALU.
- Accepts MULT/MULTU/DIV/DIVU, runs iterative shift-add multiply or restoring divide over 32 cycles, writes HI/LO.
- Holds the pipeline stall line while busy.
- Execute-stage control decode drives start/op; downstream stages read hi_out/lo_out (MFHI/MFLO).

---
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit beside the execute-stage ALU. Runs
//   MULT/MULTU as 32-step shift-add and DIV/DIVU as 32-step restoring
//   divide, then writes HI/LO and pulses done. Stalls the pipeline while busy.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-high reset
//   start        request, honoured only in IDLE
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   BusA, BusB   multiplicand/dividend, multiplier/divisor
//   flush        squash the operation in flight
//   stall_out    holds upstream pipeline registers
//   busy         high in CALC and FIX
//   done         one-cycle pulse, HI/LO already hold the result
//   div_by_zero  qualifies done for a divide with BusB == 0
//   hi_out       HI register
//   lo_out       LO register
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one multiply/divide iteration per cycle, WIDTH cycles
// FIX   | apply signs and write HI/LO (skipped write on flush)
// DONE  | result visible, done pulse, back to IDLE

module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;     // product accumulator; low half is dividend/quotient for divides
  logic [WIDTH-1:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0]   b_q;       // multiplicand / divisor magnitude
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic               dbz_q;

  logic               a_neg, b_neg, b_zero, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign a_neg  = ~op[0] & BusA[WIDTH-1];
  assign b_neg  = ~op[0] & BusB[WIDTH-1];
  assign a_mag  = a_neg ? -BusA : BusA;
  assign b_mag  = b_neg ? -BusB : BusB;
  assign b_zero = (BusB == '0);
  // flush beats a simultaneous start
  assign accept = (state_q == S_IDLE) & start & ~flush;

  // shift-add step: add multiplicand into the upper half when LSB set, then shift right
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  // restoring step: trial subtract on the shifted remainder; borrow means restore
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -rem_q : rem_q;

  assign busy        = (state_q == S_CALC) | (state_q == S_FIX);
  assign stall_out   = ((state_q == S_IDLE) & start) | busy;
  assign done        = (state_q == S_DONE);
  assign div_by_zero = (state_q == S_DONE) & dbz_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (op[1] & b_zero) ? S_FIX : S_CALC;
      S_CALC: begin
        if (flush)                                state_d = S_IDLE;
        else if (cnt_q == CNT_W'(WIDTH - 1))      state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_out    <= '0;
      lo_out    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          cnt_q     <= '0;
          rem_q     <= '0;
          b_q       <= b_mag;
          is_div_q  <= op[1];
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          dbz_q     <= op[1] & b_zero;
          // divide by zero returns the raw dividend in HI, so keep it unsigned-untouched
          acc_q     <= {{WIDTH{1'b0}}, (op[1] & b_zero) ? BusA : a_mag};
        end
        S_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div_q) begin
            rem_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
        end
        S_FIX: if (!flush) begin
          if (dbz_q) begin
            hi_out <= acc_q[WIDTH-1:0];
            lo_out <= '1;
          end else if (is_div_q) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end else begin
            {hi_out, lo_out} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset, start, flush;
  logic [1:0]  op;
  logic [31:0] BusA, BusB;
  logic        stall_out, busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .BusA(BusA), .BusB(BusB), .flush(flush),
    .stall_out(stall_out), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == 0) begin
          z = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; BusA = a; BusB = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // waits for done; lat is cycles since the start cycle, -1 on timeout
  task automatic wait_done(input int base, output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    lat = (done === 1'b1) ? n + base : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; BusA = '0; BusB = '0;
    tick(); tick();
    total++;
    if (hi_out !== 0 || lo_out !== 0 || busy !== 0 || stall_out !== 0 || done !== 0 || div_by_zero !== 0) begin
      bad++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b stall=%b done=%b dbz=%b required all zero",
               hi_out, lo_out, busy, stall_out, done, div_by_zero);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_multu_max();
    int stall_bad;
    stall_bad = 0;
    op = 2'b01; BusA = 32'hFFFF_FFFF; BusB = 32'hFFFF_FFFF; start = 1'b1;
    #1;
    if (stall_out !== 1'b1) stall_bad++;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (stall_out !== 1'b1 || done !== 1'b0) stall_bad++;
      tick();
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL multu_stall: %0d cycles wrong, required stall high t..t+33 with no done", stall_bad);
    end
    total++;
    if (done !== 1'b1 || hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h0000_0001 || stall_out !== 1'b0) begin
      bad++;
      $display("FAIL multu_max: done=%b hi=%h lo=%h stall=%b required 1 fffffffe 00000001 0",
               done, hi_out, lo_out, stall_out);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: done=%b required 0 after one cycle", done);
    end
  endtask

  task automatic test_signed();
    int lat;
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, lat);
    total++;
    if (lat != 34 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFF1 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL mult_neg: lat=%0d hi=%h lo=%h dbz=%b required 34 ffffffff fffffff1 0",
               lat, hi_out, lo_out, div_by_zero);
    end
    tick();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, lat);
    total++;
    if (lat != 34 || lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL div_neg: lat=%0d hi=%h lo=%h required 34 ffffffff fffffffd", lat, hi_out, lo_out);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int lat;
    issue(2'b11, 32'd100, 32'd0);
    wait_done(1, lat);
    total++;
    if (lat != 2 || div_by_zero !== 1'b1 || hi_out !== 32'd100 || lo_out !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL divu_zero: lat=%0d dbz=%b hi=%h lo=%h required 2 1 00000064 ffffffff",
               lat, div_by_zero, hi_out, lo_out);
    end
    tick();
    total++;
    if (div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL dbz_clear: dbz=%b required 0 after done", div_by_zero);
    end
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, lat);
    total++;
    if (lat != 34 || lo_out !== 32'h8000_0000 || hi_out !== 32'h0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL div_overflow: lat=%0d hi=%h lo=%h dbz=%b required 34 00000000 80000000 0",
               lat, hi_out, lo_out, div_by_zero);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat, dones;
    issue(2'b01, 32'd3, 32'd4);
    wait_done(1, lat);
    total++;
    if (lat != 34 || hi_out !== 32'd0 || lo_out !== 32'd12) begin
      bad++;
      $display("FAIL multu_small: lat=%0d hi=%h lo=%h required 34 0 c", lat, hi_out, lo_out);
    end
    tick();
    issue(2'b11, 32'd50, 32'd7);
    for (int k = 1; k < 10; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || stall_out !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd12) begin
      bad++;
      $display("FAIL flush_calc: busy=%b stall=%b hi=%h lo=%h required 0 0 0 c", busy, stall_out, hi_out, lo_out);
    end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0 || lo_out !== 32'd12) begin
      bad++;
      $display("FAIL flush_no_done: dones=%0d lo=%h required 0 c", dones, lo_out);
    end
    op = 2'b01; BusA = 32'd9; BusB = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_start_idle: busy=%b required 0", busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat, dones;
    issue(2'b01, 32'd1000, 32'd3);
    for (int k = 1; k < 5; k++) tick();
    op = 2'b11; BusA = 32'd77; BusB = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(6, lat);
    total++;
    if (lat != 34 || hi_out !== 32'd0 || lo_out !== 32'd3000) begin
      bad++;
      $display("FAIL start_while_busy: lat=%0d hi=%h lo=%h required 34 0 bb8", lat, hi_out, lo_out);
    end
    // start raised during DONE must be ignored
    op = 2'b01; BusA = 32'd2; BusB = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || lo_out !== 32'd3000) begin
      bad++;
      $display("FAIL start_in_done: busy=%b lo=%h required 0 bb8", busy, lo_out);
    end
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL extra_done: dones=%0d required 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] eh, el;
    logic ez;
    issue(2'b00, 32'h1234_5678, 32'hFFFF_0001);
    for (int k = 1; k < 20; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 0 || stall_out !== 0 || done !== 0 || hi_out !== 0 || lo_out !== 0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b stall=%b done=%b hi=%h lo=%h required all zero",
               busy, stall_out, done, hi_out, lo_out);
    end
    model(2'b10, 32'd1001, 32'd10, eh, el, ez);
    issue(2'b10, 32'd1001, 32'd10);
    wait_done(1, lat);
    total++;
    if (lat != 34 || hi_out !== eh || lo_out !== el || div_by_zero !== ez) begin
      bad++;
      $display("FAIL after_reset: lat=%0d hi=%h lo=%h required 34 %h %h", lat, hi_out, lo_out, eh, el);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, elat;
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
    logic        ez;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: a = 32'h8000_0000 | (a & 32'h1);
        default: b = $urandom;
      endcase
      if (i % 7 == 0) b = 32'd0;
      model(o, a, b, eh, el, ez);
      elat = ez ? 2 : 34;
      issue(o, a, b);
      wait_done(1, lat);
      total++;
      if (lat != elat || hi_out !== eh || lo_out !== el || div_by_zero !== ez) begin
        bad++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dbz=%b required %0d %h %h %b",
                 i, o, a, b, lat, hi_out, lo_out, div_by_zero, elat, eh, el, ez);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
